// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - classifies a debounced button into click, double click and long press
module button_event_decoder #(
   parameter int CNT_WIDTH  = 4,
   parameter int LONG_TICKS = 8,
   parameter int GAP_TICKS  = 5
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_button,
   output logic o_click,
   output logic o_double_click,
   output logic o_long_press,
   output logic o_busy
);

   typedef enum logic [2:0] {
      WAIT_REL,
      IDLE,
      PRESS1,
      GAP,
      PRESS2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_TICKS - 1);
   localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(GAP_TICKS - 1);

   state_t               state;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 b_q;
   logic                 b_vld;

   // b_vld keeps the reset value of b_q from being mistaken for a release,
   // so a button held across reset stays in WAIT_REL until truly let go.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state          <= WAIT_REL;
         cnt            <= '0;
         b_q            <= 1'b0;
         b_vld          <= 1'b0;
         o_click        <= 1'b0;
         o_double_click <= 1'b0;
         o_long_press   <= 1'b0;
         o_busy         <= 1'b0;
      end else begin
         b_q            <= i_button;
         b_vld          <= 1'b1;
         o_click        <= 1'b0;
         o_double_click <= 1'b0;
         o_long_press   <= 1'b0;
         case (state)
            WAIT_REL: begin
               if (b_vld && !b_q) begin
                  state  <= IDLE;
                  o_busy <= 1'b0;
               end else begin
                  o_busy <= 1'b1;
               end
            end
            IDLE: begin
               if (b_q) begin
                  state  <= PRESS1;
                  cnt    <= '0;
                  o_busy <= 1'b1;
               end else begin
                  o_busy <= 1'b0;
               end
            end
            PRESS1: begin
               o_busy <= 1'b1;
               if (!b_q) begin
                  state <= GAP;
                  cnt   <= '0;
               end else if (cnt == LONG_LAST) begin
                  o_long_press <= 1'b1;
                  state        <= WAIT_REL;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            GAP: begin
               // A press on the final gap tick beats the click timeout.
               if (b_q) begin
                  state  <= PRESS2;
                  o_busy <= 1'b1;
               end else if (cnt == GAP_LAST) begin
                  o_click <= 1'b1;
                  state   <= IDLE;
                  o_busy  <= 1'b0;
               end else begin
                  cnt    <= cnt + 1'b1;
                  o_busy <= 1'b1;
               end
            end
            PRESS2: begin
               if (!b_q) begin
                  o_double_click <= 1'b1;
                  state          <= IDLE;
                  o_busy         <= 1'b0;
               end else begin
                  o_busy <= 1'b1;
               end
            end
            default: begin
               state  <= WAIT_REL;
               o_busy <= 1'b1;
            end
         endcase
      end
   end

endmodule
